// File: rtl/alu4_pkg.sv
// Shared types, opcodes and the result-packing helper for the 4-bit ALU op sequencer.
package alu4_pkg;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned RES_W = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } alu_req_t;

    typedef struct packed {
        logic [RES_W-1:0] result;
        logic             carry;
        logic             zero;
        logic             err;
    } alu_res_t;

    // Bundles a result with its flags; zero always tracks the packed result.
    function automatic alu_res_t pack_res(input logic [RES_W-1:0] result,
                                          input logic carry, input logic err);
        alu_res_t r;
        r.result = result;
        r.carry  = carry;
        r.zero   = (result == '0);
        r.err    = err;
        return r;
    endfunction

endpackage

// File: rtl/alu4_iter_unit.sv
// Iterative MUL/DIV core: shift-add multiply or restoring divide, one step per enabled cycle.
module alu4_iter_unit
    import alu4_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_div,
    output logic             done,
    output logic [RES_W-1:0] result
);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;

    logic [CNT_W-1:0] bit_idx;
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quot_n;
    logic [RES_W-1:0] addend;
    logic             last;

    // One restoring-division step (MSB of A first) and one partial product per cycle.
    always_comb begin
        bit_idx = CNT_W'(WIDTH - 1) - cnt;
        trial   = {rem, a[bit_idx]};
        ge      = (trial >= {1'b0, b});
        rem_n   = ge ? WIDTH'(trial - {1'b0, b}) : trial[WIDTH-1:0];
        quot_n  = {quot[WIDTH-2:0], ge};
        addend  = b[cnt] ? (RES_W'(a) << cnt) : '0;
        last    = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
            rem     <= '0;
            quot    <= '0;
            result  <= '0;
        end else if (ena) begin
            if (start) begin
                running <= 1'b1;
                cnt     <= '0;
                done    <= 1'b0;
                rem     <= '0;
                quot    <= '0;
                result  <= '0;
            end else if (running) begin
                cnt <= cnt + CNT_W'(1);
                if (is_div) begin
                    rem  <= rem_n;
                    quot <= quot_n;
                    if (last) begin
                        result <= {rem_n, quot_n};
                    end
                end else begin
                    result <= result + addend;
                end
                if (last) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu4_op_sequencer.sv
// Valid/ready ALU op sequencer: single-cycle logic/arith ops, iterative MUL/DIV, held result.
module alu4_op_sequencer
    import alu4_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err,
    output logic             busy
);

    state_t   state, state_n;
    alu_req_t req_q, req_n;
    alu_res_t res_q, res_n;
    logic     use_iter_q, use_iter_n;
    logic     setup_q, setup_n;
    logic     out_valid_n;
    logic     iter_start_c;
    logic     iter_done;
    logic [RES_W-1:0] iter_result;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    alu_res_t       single_res;

    alu4_iter_unit u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .start  (iter_start_c),
        .a      (req_q.a),
        .b      (req_q.b),
        .is_div (req_q.op == OP_DIV),
        .done   (iter_done),
        .result (iter_result)
    );

    // Single-cycle results; DIV only lands here when B is zero.
    always_comb begin
        sum        = {1'b0, req_q.a} + {1'b0, req_q.b};
        diff       = {1'b0, req_q.a} - {1'b0, req_q.b};
        single_res = pack_res('0, 1'b0, 1'b1);
        case (req_q.op)
            OP_ADD:  single_res = pack_res(RES_W'(sum[WIDTH-1:0]), sum[WIDTH], 1'b0);
            OP_SUB:  single_res = pack_res(RES_W'(diff[WIDTH-1:0]), diff[WIDTH], 1'b0);
            OP_AND:  single_res = pack_res(RES_W'(req_q.a & req_q.b), 1'b0, 1'b0);
            OP_OR:   single_res = pack_res(RES_W'(req_q.a | req_q.b), 1'b0, 1'b0);
            OP_XOR:  single_res = pack_res(RES_W'(req_q.a ^ req_q.b), 1'b0, 1'b0);
            OP_DIV:  single_res = pack_res({req_q.a, {WIDTH{1'b1}}}, 1'b0, 1'b1);
            default: single_res = pack_res('0, 1'b0, 1'b1);
        endcase
    end

    // Next-state logic; with ena low every default holds, freezing the whole block.
    always_comb begin
        state_n      = state;
        req_n        = req_q;
        res_n        = res_q;
        use_iter_n   = use_iter_q;
        setup_n      = setup_q;
        out_valid_n  = out_valid;
        iter_start_c = 1'b0;
        if (ena) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_n    = EXEC;
                        req_n      = '{op: in_op, a: in_a, b: in_b};
                        use_iter_n = (in_op == OP_MUL) || ((in_op == OP_DIV) && (in_b != '0));
                        setup_n    = 1'b1;
                    end
                end
                EXEC: begin
                    // First EXEC cycle arms the iterative core; completion is seen one cycle later.
                    if (setup_q) begin
                        setup_n      = 1'b0;
                        iter_start_c = use_iter_q;
                    end else if (!use_iter_q || iter_done) begin
                        state_n     = DONE;
                        out_valid_n = 1'b1;
                        res_n       = use_iter_q ? pack_res(iter_result, 1'b0, 1'b0) : single_res;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_n     = IDLE;
                        out_valid_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_q      <= '0;
            res_q      <= '0;
            use_iter_q <= 1'b0;
            setup_q    <= 1'b0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            req_q      <= req_n;
            res_q      <= res_n;
            use_iter_q <= use_iter_n;
            setup_q    <= setup_n;
            out_valid  <= out_valid_n;
            in_ready   <= (state_n == IDLE);
            busy       <= (state_n != IDLE);
        end
    end

    assign out_result = res_q.result;
    assign out_carry  = res_q.carry;
    assign out_zero   = res_q.zero;
    assign out_err    = res_q.err;

endmodule
